// File: rtl/sift_pkg.sv
// Shared definitions for the SIFT keypoint path: field widths, the arbiter
// FSM encoding and the layer tags carried on every stored keypoint.
package sift_pkg;

    localparam int KP_ROW_W = 9;
    localparam int KP_COL_W = 10;
    localparam int KP_W     = KP_ROW_W + KP_COL_W;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic LAYER0 = 1'b0;
    localparam logic LAYER1 = 1'b1;

    // One SRAM word: the layer tag on top of the {row, col} keypoint.
    typedef struct packed {
        logic            layer;
        logic [KP_W-1:0] kp;
    } kp_entry_t;

endpackage

// File: rtl/kp_fifo.sv
// Small synchronous FIFO for one keypoint stream. A push into a full FIFO is
// only taken when the same cycle also pops; otherwise it is dropped and the
// parent is expected to flag the loss. flush empties the FIFO and overrides
// any push/pop in that cycle.
module kp_fifo
    import sift_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = KP_W,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           push,
    input  logic [W-1:0]   din,
    input  logic           pop,
    output logic [W-1:0]   dout,
    output logic           full,
    output logic           empty,
    output logic [PTR_W:0] count
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign pop_ok  = pop && !empty && !flush;
    assign push_ok = push && (!full || pop_ok) && !flush;

    // Next-state pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer/occupancy registers; cleared by reset so the FIFO starts empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/keypoint_wr_arbiter.sv
// Merges the two per-layer keypoint streams into the single-port keypoint
// SRAM: one FIFO per layer, round-robin drain at one write per cycle,
// frame sequencing (start / frame_end / done) and saturating write count.
module keypoint_wr_arbiter
    import sift_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 12,
    parameter int MAX_KP     = 4095
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              frame_end,
    input  logic              kp1_we,
    input  logic [KP_W-1:0]   kp1_din,
    input  logic              kp2_we,
    input  logic [KP_W-1:0]   kp2_din,
    output logic              kp_stall,
    output logic              kp_we,
    output logic [ADDR_W-1:0] kp_addr,
    output logic [KP_W:0]     kp_din,
    output logic [ADDR_W:0]   kp_count,
    output logic              overflow,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CAP       = CNT_W'(MAX_KP + 1);
    localparam logic [PTR_W:0]   STALL_LVL = (PTR_W+1)'(FIFO_DEPTH - 1);

    logic [1:0]        state_q, state_d;
    logic              rr_q, rr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    kp_entry_t         din_q, din_d;

    logic              start_ok;
    logic              accept;
    logic              push0, push1;
    logic              pop0, pop1, pop_any;
    logic              drop0, drop1;
    logic [KP_W-1:0]   dout0, dout1;
    logic              full0, full1;
    logic              empty0, empty1;
    logic [PTR_W:0]    cnt0, cnt1;

    // A start seen in DONE is ignored: DONE always returns to IDLE first.
    assign start_ok = start && (state_q != ST_DONE);
    assign accept   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign push0    = kp1_we && accept;
    assign push1    = kp2_we && accept;

    // Round robin only matters when both layers are waiting.
    assign pop0    = !empty0 && (empty1 || (rr_q == LAYER0));
    assign pop1    = !empty1 && (empty0 || (rr_q == LAYER1));
    assign pop_any = pop0 || pop1;

    assign drop0 = push0 && full0 && !pop0;
    assign drop1 = push1 && full1 && !pop1;

    kp_fifo #(.DEPTH(FIFO_DEPTH), .W(KP_W)) u_fifo0 (
        .clk   (clk),
        .rst   (rst),
        .flush (start_ok),
        .push  (push0),
        .din   (kp1_din),
        .pop   (pop0),
        .dout  (dout0),
        .full  (full0),
        .empty (empty0),
        .count (cnt0)
    );

    kp_fifo #(.DEPTH(FIFO_DEPTH), .W(KP_W)) u_fifo1 (
        .clk   (clk),
        .rst   (rst),
        .flush (start_ok),
        .push  (push1),
        .din   (kp2_din),
        .pop   (pop1),
        .dout  (dout1),
        .full  (full1),
        .empty (empty1),
        .count (cnt1)
    );

    assign kp_stall = (cnt0 >= STALL_LVL) || (cnt1 >= STALL_LVL);
    assign kp_we    = we_q;
    assign kp_addr  = addr_q;
    assign kp_din   = din_q;
    assign kp_count = cnt_q;
    assign overflow = ovf_q;
    assign busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done     = (state_q == ST_DONE);

    // Frame FSM, arbitration pointer, write issue and overflow tracking.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;
        if (start_ok) begin
            state_d = ST_RUN;
            rr_d    = LAYER0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            addr_d  = '0;
        end else begin
            if (pop0 && !empty1)      rr_d = LAYER1;
            else if (pop1 && !empty0) rr_d = LAYER0;

            if (pop_any) begin
                if (cnt_q != CAP) begin
                    we_d        = 1'b1;
                    addr_d      = cnt_q[ADDR_W-1:0];
                    din_d.layer = pop1 ? LAYER1 : LAYER0;
                    din_d.kp    = pop1 ? dout1 : dout0;
                    cnt_d       = cnt_q + 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end
            if (drop0 || drop1) ovf_d = 1'b1;

            case (state_q)
                ST_RUN:   if (frame_end) state_d = ST_DRAIN;
                ST_DRAIN: if (empty0 && empty1 && !push0 && !push1) state_d = ST_DONE;
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = state_q;
            endcase
        end
    end

    // Control and registered SRAM-side outputs; everything reads 0 in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rr_q    <= LAYER0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

endmodule

// File: tb/tb_keypoint_wr_arbiter.sv
// Testbench for keypoint_wr_arbiter: directed frames plus random frames, each
// cycle compared against a queue-based behavioural model of the arbiter.
module tb_keypoint_wr_arbiter;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 12;
    localparam int MAXKP  = 11;
    localparam int CAP    = MAXKP + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              start, frame_end;
    logic              kp1_we, kp2_we;
    logic [18:0]       kp1_din, kp2_din;
    logic              kp_stall, kp_we, overflow, busy, done;
    logic [ADDR_W-1:0] kp_addr;
    logic [19:0]       kp_din;
    logic [ADDR_W:0]   kp_count;

    int checks   = 0;
    int failures = 0;

    keypoint_wr_arbiter #(.FIFO_DEPTH(DEPTH), .ADDR_W(ADDR_W), .MAX_KP(MAXKP)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .frame_end (frame_end),
        .kp1_we    (kp1_we),
        .kp1_din   (kp1_din),
        .kp2_we    (kp2_we),
        .kp2_din   (kp2_din),
        .kp_stall  (kp_stall),
        .kp_we     (kp_we),
        .kp_addr   (kp_addr),
        .kp_din    (kp_din),
        .kp_count  (kp_count),
        .overflow  (overflow),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Behavioural model: per-layer queues, a frame phase, a write counter.
    logic [18:0] m_q0[$];
    logic [18:0] m_q1[$];
    int          m_rr, m_cnt, m_phase;   // phase: 0 idle, 1 run, 2 drain, 3 done
    bit          m_ovf, m_we;
    int          m_addr;
    logic [19:0] m_din;

    task automatic model_reset();
        m_q0.delete(); m_q1.delete();
        m_rr = 0; m_cnt = 0; m_phase = 0; m_ovf = 0;
        m_we = 0; m_addr = 0; m_din = '0;
    endtask

    task automatic model_step(input bit st, input bit fe, input bit w1, input logic [18:0] d1,
                              input bit w2, input logic [18:0] d2);
        int sel;
        int nxt;
        bit acc;
        logic [18:0] e;
        acc  = (m_phase == 1) || (m_phase == 2);
        m_we = 0;
        if (st && m_phase != 3) begin
            m_q0.delete(); m_q1.delete();
            m_rr = 0; m_cnt = 0; m_ovf = 0; m_addr = 0; m_phase = 1;
            return;
        end
        nxt = m_phase;
        if (m_phase == 1 && fe) nxt = 2;
        if (m_phase == 2 && m_q0.size() == 0 && m_q1.size() == 0 && !w1 && !w2) nxt = 3;
        if (m_phase == 3) nxt = 0;
        sel = -1;
        if (m_q0.size() > 0 && m_q1.size() > 0) begin
            sel  = m_rr;
            m_rr = 1 - m_rr;
        end else if (m_q0.size() > 0) sel = 0;
        else if (m_q1.size() > 0) sel = 1;
        if (sel >= 0) begin
            e = (sel == 0) ? m_q0.pop_front() : m_q1.pop_front();
            if (m_cnt < CAP) begin
                m_we   = 1;
                m_addr = m_cnt;
                m_din  = {(sel == 1), e};
                m_cnt++;
            end else m_ovf = 1;
        end
        if (acc && w1) begin
            if (m_q0.size() < DEPTH) m_q0.push_back(d1); else m_ovf = 1;
        end
        if (acc && w2) begin
            if (m_q1.size() < DEPTH) m_q1.push_back(d2); else m_ovf = 1;
        end
        m_phase = nxt;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        bit stall;
        stall = (m_q0.size() >= DEPTH - 1) || (m_q1.size() >= DEPTH - 1);
        chk("kp_we",    32'(kp_we),    32'(m_we));
        chk("kp_addr",  32'(kp_addr),  32'(m_addr));
        chk("kp_din",   32'(kp_din),   32'(m_din));
        chk("kp_count", 32'(kp_count), 32'(m_cnt));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("busy",     32'(busy),     32'(m_phase == 1 || m_phase == 2));
        chk("done",     32'(done),     32'(m_phase == 3));
        chk("kp_stall", 32'(kp_stall), 32'(stall));
    endtask

    // Drive one cycle of inputs, let the DUT and model take the edge, compare.
    task automatic cycle(input bit st, input bit fe, input bit w1, input logic [18:0] d1,
                         input bit w2, input logic [18:0] d2);
        start = st; frame_end = fe;
        kp1_we = w1; kp1_din = d1; kp2_we = w2; kp2_din = d2;
        @(posedge clk);
        model_step(st, fe, w1, d1, w2, d2);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, '0, 0, '0);
    endtask

    initial begin
        rst = 1'b1; start = 0; frame_end = 0;
        kp1_we = 0; kp2_we = 0; kp1_din = '0; kp2_din = '0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        check_all();
        rst = 1'b0;

        // Single stream, three keypoints.
        cycle(1, 0, 0, '0, 0, '0);
        cycle(0, 0, 1, 19'h00001, 0, '0);
        chk("t1_latency_we", 32'(kp_we), 32'd0);
        cycle(0, 0, 1, 19'h00002, 0, '0);
        chk("t1_din0", 32'(kp_din), 32'h00001);
        chk("t1_addr0", 32'(kp_addr), 32'd0);
        cycle(0, 0, 1, 19'h00003, 0, '0);
        chk("t1_din1", 32'(kp_din), 32'h00002);
        chk("t1_addr1", 32'(kp_addr), 32'd1);
        cycle(0, 1, 0, '0, 0, '0);
        chk("t1_din2", 32'(kp_din), 32'h00003);
        chk("t1_addr2", 32'(kp_addr), 32'd2);
        chk("t1_count", 32'(kp_count), 32'd3);
        idle(4);

        // Contention: both layers for four cycles.
        cycle(1, 0, 0, '0, 0, '0);
        for (int i = 0; i < 4; i++) cycle(0, i == 3, 1, 19'(32'h10 + i), 1, 19'(32'h20 + i));
        idle(8);
        chk("t2_count", 32'(kp_count), 32'd8);
        chk("t2_ovf", 32'(overflow), 32'd0);

        // Sustained dual push long enough to overflow the FIFOs.
        cycle(1, 0, 0, '0, 0, '0);
        for (int i = 0; i < 10; i++) cycle(0, i == 9, 1, 19'(32'h100 + i), 1, 19'(32'h200 + i));
        chk("t3_ovf", 32'(overflow), 32'd1);
        idle(12);

        // Drain/done, then pushes in IDLE are ignored.
        cycle(1, 0, 0, '0, 0, '0);
        cycle(0, 0, 1, 19'h00aa1, 1, 19'h00bb1);
        cycle(0, 1, 1, 19'h00aa2, 1, 19'h00bb2);
        idle(6);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 19'h7ffff, 1, 19'h7fffe);
        chk("t4_idle_count", 32'(kp_count), 32'd4);

        // Capacity: more keypoints than the SRAM holds.
        cycle(1, 0, 0, '0, 0, '0);
        for (int i = 0; i < CAP + 2; i++) cycle(0, i == CAP + 1, 1, 19'(i), 0, '0);
        chk("t5_count_sat", 32'(kp_count), 32'(CAP));
        chk("t5_ovf", 32'(overflow), 32'd1);
        idle(5);

        // Restart mid-RUN with entries queued.
        cycle(1, 0, 0, '0, 0, '0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 19'(32'h300 + i), 1, 19'(32'h400 + i));
        cycle(1, 0, 0, '0, 0, '0);
        chk("t6_restart_count", 32'(kp_count), 32'd0);
        cycle(0, 0, 1, 19'h00555, 0, '0);
        cycle(0, 1, 0, '0, 0, '0);
        chk("t6_first_addr", 32'(kp_addr), 32'd0);
        chk("t6_first_din", 32'(kp_din), 32'h00555);
        idle(4);

        // Asynchronous reset in the middle of a burst.
        cycle(1, 0, 0, '0, 0, '0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 19'(32'h600 + i), 1, 19'(32'h700 + i));
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk); #1;
        rst = 1'b0;
        start = 0; kp1_we = 0; kp2_we = 0;
        idle(2);

        // Random frames.
        for (int f = 0; f < 10; f++) begin
            int len;
            len = $urandom_range(4, 20);
            cycle(1, 0, 0, '0, 0, '0);
            for (int i = 0; i < len; i++) begin
                cycle(($urandom_range(0, 29) == 0), (i == len - 1),
                      $urandom_range(0, 1) == 1, 19'($urandom),
                      $urandom_range(0, 2) != 0, 19'($urandom));
            end
            for (int i = 0; i < 14; i++)
                cycle(0, 0, $urandom_range(0, 5) == 0, 19'($urandom),
                      $urandom_range(0, 5) == 0, 19'($urandom));
            idle(12);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
